pipeline_stall_controller: RTL and testbench

//  Consumer of the ID-stage Hazard signal, the EXE-stage branch-taken signal and the SRAM wait signal.

---
 rtl/pipeline_stall_controller.sv | 116 +++++++++++
 tb/tb_pipeline_stall_controller.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/pipeline_stall_controller.sv
// rtl/pipeline_stall_controller.sv - resolves hazard, branch flush and SRAM wait into pipeline stage controls.
// Optional perf counters are enabled by defining STALL_PERF_CNT_EN.
module pipeline_stall_controller #(
   parameter int unsigned FLUSH_CYCLES  = 1,
   parameter int unsigned STALL_TIMEOUT = 255
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        hazard_i,
   input  logic        branch_taken_i,
   input  logic        mem_stall_i,
   output logic        freeze_all_o,
   output logic        freeze_if_o,
   output logic        flush_if_id_o,
   output logic        bubble_id_exe_o,
   output logic [1:0]  state_o,
   output logic        stall_timeout_o
`ifdef STALL_PERF_CNT_EN
   ,
   output logic [31:0] hazard_cycles_o,
   output logic [31:0] mem_cycles_o,
   output logic [31:0] flush_events_o
`endif
);

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_HAZ   = 2'd1,
      ST_MEMW  = 2'd2,
      ST_FLUSH = 2'd3
   } state_t;

   localparam logic [2:0]  FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);
   localparam logic [15:0] TIMEOUT_W  = 16'(STALL_TIMEOUT);

   state_t      state_q, state_d;
   logic [2:0]  fcnt_q, fcnt_d;
   logic [15:0] scnt_q, scnt_d;
   logic        timeout_q, timeout_d;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= ST_RUN;
         fcnt_q    <= 3'd0;
         scnt_q    <= 16'd0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         fcnt_q    <= fcnt_d;
         scnt_q    <= scnt_d;
         timeout_q <= timeout_d;
      end
   end

   always_comb begin
      freeze_all_o    = 1'b0;
      flush_if_id_o   = 1'b0;
      freeze_if_o     = 1'b0;
      bubble_id_exe_o = 1'b0;
      state_d         = ST_RUN;
      fcnt_d          = fcnt_q;
      scnt_d          = 16'd0;

      // SRAM wait dominates; a pending flush or hazard is simply held over.
      freeze_all_o    = mem_stall_i;
      flush_if_id_o   = ~mem_stall_i & (branch_taken_i | (fcnt_q != 3'd0));
      freeze_if_o     = ~mem_stall_i & ~flush_if_id_o & hazard_i;
      bubble_id_exe_o = flush_if_id_o | freeze_if_o;

      if (!mem_stall_i) begin
         if (branch_taken_i)
            fcnt_d = FLUSH_LOAD;
         else if (fcnt_q != 3'd0)
            fcnt_d = fcnt_q - 3'd1;
      end

      if (mem_stall_i)
         state_d = ST_MEMW;
      else if (flush_if_id_o)
         state_d = ST_FLUSH;
      else if (freeze_if_o)
         state_d = ST_HAZ;

      if (state_d != ST_RUN)
         scnt_d = (scnt_q == TIMEOUT_W) ? scnt_q : scnt_q + 16'd1;

      timeout_d = timeout_q | (scnt_d == TIMEOUT_W);
   end

   assign state_o         = state_q;
   assign stall_timeout_o = timeout_q;

`ifdef STALL_PERF_CNT_EN
   logic [31:0] hazard_cycles_q, mem_cycles_q, flush_events_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         hazard_cycles_q <= 32'd0;
         mem_cycles_q    <= 32'd0;
         flush_events_q  <= 32'd0;
      end else begin
         if (freeze_if_o && hazard_cycles_q != 32'hFFFF_FFFF)
            hazard_cycles_q <= hazard_cycles_q + 32'd1;
         if (freeze_all_o && mem_cycles_q != 32'hFFFF_FFFF)
            mem_cycles_q <= mem_cycles_q + 32'd1;
         if (branch_taken_i && !mem_stall_i && flush_events_q != 32'hFFFF_FFFF)
            flush_events_q <= flush_events_q + 32'd1;
      end
   end

   assign hazard_cycles_o = hazard_cycles_q;
   assign mem_cycles_o    = mem_cycles_q;
   assign flush_events_o  = flush_events_q;
`endif

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// tb/tb_pipeline_stall_controller.sv - directed and randomized checks against a cycle-level reference model.
module tb_pipeline_stall_controller;

   localparam int FC = 2;
   localparam int TO = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       hazard, branch_taken, mem_stall;
   logic       freeze_all, freeze_if, flush_if_id, bubble_id_exe;
   logic [1:0] state;
   logic       stall_timeout;
`ifdef STALL_PERF_CNT_EN
   logic [31:0] hazard_cycles, mem_cycles, flush_events;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   // reference model: remaining flush cycles, current non-RUN run length, sticky flag
   int      m_state;
   int      m_flush_left;
   int      m_stall_len;
   bit      m_timeout;
   longint  m_haz, m_mem, m_fl;

   pipeline_stall_controller #(.FLUSH_CYCLES(FC), .STALL_TIMEOUT(TO)) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .hazard_i       (hazard),
      .branch_taken_i (branch_taken),
      .mem_stall_i    (mem_stall),
      .freeze_all_o   (freeze_all),
      .freeze_if_o    (freeze_if),
      .flush_if_id_o  (flush_if_id),
      .bubble_id_exe_o(bubble_id_exe),
      .state_o        (state),
      .stall_timeout_o(stall_timeout)
`ifdef STALL_PERF_CNT_EN
      ,
      .hazard_cycles_o(hazard_cycles),
      .mem_cycles_o   (mem_cycles),
      .flush_events_o (flush_events)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_state = 0; m_flush_left = 0; m_stall_len = 0; m_timeout = 0;
      m_haz = 0; m_mem = 0; m_fl = 0;
   endtask

   task automatic check_regs();
      chk("state", state, m_state);
      chk("stall_timeout", stall_timeout, m_timeout);
`ifdef STALL_PERF_CNT_EN
      chk("hazard_cycles", hazard_cycles, 32'(m_haz));
      chk("mem_cycles", mem_cycles, 32'(m_mem));
      chk("flush_events", flush_events, 32'(m_fl));
`endif
   endtask

   // Called just after a falling edge; returns at the next falling edge.
   task automatic step(input bit h, input bit b, input bit m);
      bit e_fa, e_fl, e_fi, e_bb;
      int nxt;
      hazard = h; branch_taken = b; mem_stall = m;
      #1;
      e_fa = m;
      e_fl = !m && (b || m_flush_left > 0);
      e_fi = !m && !e_fl && h;
      e_bb = e_fl || e_fi;
      chk("freeze_all", freeze_all, e_fa);
      chk("flush_if_id", flush_if_id, e_fl);
      chk("freeze_if", freeze_if, e_fi);
      chk("bubble_id_exe", bubble_id_exe, e_bb);
      check_regs();
      if (m) nxt = 2;
      else if (e_fl) nxt = 3;
      else if (e_fi) nxt = 1;
      else nxt = 0;
      @(posedge clk);
      if (!m) begin
         if (b) m_flush_left = FC - 1;
         else if (m_flush_left > 0) m_flush_left--;
      end
      if (nxt != 0) m_stall_len = (m_stall_len + 1 > TO) ? TO : m_stall_len + 1;
      else m_stall_len = 0;
      if (m_stall_len == TO) m_timeout = 1;
      if (e_fi) m_haz++;
      if (m) m_mem++;
      if (b && !m) m_fl++;
      m_state = nxt;
      @(negedge clk);
   endtask

   // Asynchronous reset: effect must be visible before any clock edge.
   task automatic do_reset();
      hazard = 0; branch_taken = 0; mem_stall = 0;
      rst = 1'b1;
      model_reset();
      #1;
      chk("rst_state", state, 0);
      chk("rst_timeout", stall_timeout, 0);
      chk("rst_freeze_all", freeze_all, 0);
      chk("rst_bubble", bubble_id_exe, 0);
      check_regs();
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; hazard = 0; branch_taken = 0; mem_stall = 0;
      model_reset();
      @(negedge clk);
      do_reset();

      // three hazard cycles, two SRAM waits, one branch with hazard overlap
      repeat (3) step(1, 0, 0);
      step(0, 0, 0);
      repeat (2) step(0, 0, 1);
      step(0, 1, 1);
      step(1, 1, 0);
      step(1, 0, 0);
      step(0, 0, 0);
      step(0, 0, 0);
`ifdef STALL_PERF_CNT_EN
      chk("perf_hazard_dir", hazard_cycles, 32'd3);
      chk("perf_mem_dir", mem_cycles, 32'd3);
      chk("perf_flush_dir", flush_events, 32'd1);
`endif

      // branch, then SRAM wait holding the remaining flush cycle
      step(0, 1, 0);
      repeat (4) step(0, 0, 1);
      step(0, 0, 0);
      chk("flush_after_memw_state", state, 3);
      step(0, 0, 0);

      // mem_stall and hazard together
      step(1, 0, 1);
      step(0, 0, 0);

      // watchdog: six stall cycles, flag sticks, async reset mid-stall clears it
      do_reset();
      repeat (6) step(0, 0, 1);
      step(0, 0, 0);
      chk("timeout_sticky", stall_timeout, 1);
      step(0, 0, 1);
      step(0, 0, 1);
      do_reset();
      chk("timeout_cleared", stall_timeout, 0);

      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 49) == 0)
            do_reset();
         else
            step($urandom_range(0, 2) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 4) == 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
